// File: rtl/wb_mailbox_if.sv
// wb_mailbox_if: Wishbone classic bus bundle between the Caravel host and the mailbox
interface wb_mailbox_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone byte mailbox between Caravel host and AS2650 core; IRQ logic built only with `WB_MAILBOX_IRQ_EN
module wb_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_mailbox_if.slave wb,
  output logic [7:0]  h2c_data,
  output logic        h2c_valid,
  input  logic        h2c_ready,
  input  logic [7:0]  c2h_data,
  input  logic        c2h_valid,
  output logic        c2h_ready,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [7:0]    h2c_mem [DEPTH];
  logic [7:0]    c2h_mem [DEPTH];
  logic [AW-1:0] h2c_wp, h2c_rp, c2h_wp, c2h_rp;
  logic [CW-1:0] h2c_cnt, c2h_cnt, h2c_cnt_nx, c2h_cnt_nx;
  logic          ack, done, req, fire, wr, rd, flush;
  logic          h2c_full, h2c_push, h2c_pop, h2c_push_ok;
  logic          c2h_nf, c2h_ne, c2h_push, c2h_pop;
  logic          ovf, unf, ie;
  logic [1:0]    rs;
  logic [31:0]   status, rdata, dat_q;
  logic          unused_ok;
  assign rs   = wb.wbs_adr_i[3:2];
  assign req  = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // done holds off a second service while the master keeps the same request up
  assign fire  = req & ~ack & ~done;
  assign wr    = fire & wb.wbs_we_i;
  assign rd    = fire & ~wb.wbs_we_i;
  assign flush = wr & (rs == 2'd2) & wb.wbs_dat_i[1];
  assign h2c_full    = h2c_cnt == FULL;
  assign h2c_valid   = h2c_cnt != '0;
  assign h2c_data    = h2c_mem[h2c_rp];
  assign h2c_push    = wr & (rs == 2'd0) & wb.wbs_sel_i[0];
  assign h2c_pop     = h2c_valid & h2c_ready;
  assign h2c_push_ok = h2c_push & (~h2c_full | h2c_pop);
  assign c2h_ready   = c2h_nf;
  assign c2h_ne      = c2h_cnt != '0;
  assign c2h_push    = c2h_valid & c2h_nf;
  assign c2h_pop     = rd & (rs == 2'd0) & c2h_ne;
  assign h2c_cnt_nx  = flush ? '0 : h2c_cnt + CW'(h2c_push_ok) - CW'(h2c_pop);
  assign c2h_cnt_nx  = flush ? '0 : c2h_cnt + CW'(c2h_push) - CW'(c2h_pop);
  assign status = {12'b0, 4'(h2c_cnt), 4'b0, 4'(c2h_cnt), 3'b0, unf, ovf, ~h2c_valid, h2c_full, c2h_ne};
  always_comb
    rdata = rs == 2'd0 ? {24'b0, c2h_ne ? c2h_mem[c2h_rp] : 8'h00}
          : rs == 2'd1 ? status
          : rs == 2'd2 ? {31'b0, ie}
          : 32'b0;
  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = dat_q;
  assign unused_ok = &{1'b0, wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:5], wb.wbs_dat_i[2]};
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      ack    <= 1'b0;
      done   <= 1'b0;
      dat_q  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      c2h_nf <= 1'b1;
    end else begin
      ack    <= fire;
      done   <= req & (ack | done);
      dat_q  <= rd ? rdata : '0;
      ovf    <= (ovf & ~(wr & (rs == 2'd1) & wb.wbs_dat_i[3])) | (h2c_push & h2c_full & ~h2c_pop);
      unf    <= (unf & ~(wr & (rs == 2'd1) & wb.wbs_dat_i[4])) | (rd & (rs == 2'd0) & ~c2h_ne);
      c2h_nf <= c2h_cnt_nx != FULL;
    end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        h2c_mem[i] <= '0;
        c2h_mem[i] <= '0;
      end
      h2c_wp  <= '0;
      h2c_rp  <= '0;
      c2h_wp  <= '0;
      c2h_rp  <= '0;
      h2c_cnt <= '0;
      c2h_cnt <= '0;
    end else begin
      if (!flush && h2c_push_ok) h2c_mem[h2c_wp] <= wb.wbs_dat_i[7:0];
      if (!flush && c2h_push) c2h_mem[c2h_wp] <= c2h_data;
      h2c_wp  <= flush ? '0 : h2c_wp + AW'(h2c_push_ok);
      h2c_rp  <= flush ? '0 : h2c_rp + AW'(h2c_pop);
      c2h_wp  <= flush ? '0 : c2h_wp + AW'(c2h_push);
      c2h_rp  <= flush ? '0 : c2h_rp + AW'(c2h_pop);
      h2c_cnt <= h2c_cnt_nx;
      c2h_cnt <= c2h_cnt_nx;
    end
`ifdef WB_MAILBOX_IRQ_EN
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr && rs == 2'd2) ie <= wb.wbs_dat_i[0];
      irq_o <= ie & c2h_ne;
    end
`else
  assign ie    = 1'b0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_mailbox.sv
// tb_wb_mailbox: randomized scoreboard bench for wb_mailbox against a queue-based mailbox model
module tb_wb_mailbox;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic h2c_ready = 1'b0;
  logic c2h_valid = 1'b0;
  logic [7:0] c2h_data = 8'h00;
  logic [7:0] h2c_data;
  logic h2c_valid, c2h_ready, irq_o;
  wb_mailbox_if bus();
  wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
    .h2c_data(h2c_data), .h2c_valid(h2c_valid), .h2c_ready(h2c_ready),
    .c2h_data(c2h_data), .c2h_valid(c2h_valid), .c2h_ready(c2h_ready),
    .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  typedef struct {bit rd; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  logic [7:0] h2c_q[$];
  logic [7:0] c2h_q[$];
  bit m_ovf, m_unf, m_ie, m_irq, go, mon_on, rand_core;
  int n_chk, n_err;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask
  function automatic logic [31:0] m_status();
    int hn, cn, s;
    hn = h2c_q.size();
    cn = c2h_q.size();
    s = (cn != 0 ? 1 : 0) + (hn == DEPTH ? 2 : 0) + (hn == 0 ? 4 : 0)
      + (m_ovf ? 8 : 0) + (m_unf ? 16 : 0) + cn * 256 + hn * 65536;
    return 32'(s);
  endfunction
  // reference model: one transaction per go edge, core handshakes every edge
  always @(posedge clk) begin
    logic [1:0] rg;
    logic [31:0] d;
    bit we, hp, cp, fl, irq0;
    exp_t e;
    if (rst) begin
      h2c_q.delete();
      c2h_q.delete();
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_ie = 0;
      m_irq = 0;
    end else begin
      rg = bus.wbs_adr_i[3:2];
      d = bus.wbs_dat_i;
      we = bus.wbs_we_i;
      hp = h2c_ready && h2c_q.size() > 0;
      cp = c2h_valid && c2h_q.size() < DEPTH;
      irq0 = m_ie && c2h_q.size() > 0;
      fl = go && we && rg == 2'd2 && d[1];
      if (go) begin
        e.rd = !we;
        e.d = rg == 2'd0 ? (c2h_q.size() > 0 ? {24'h0, c2h_q[0]} : 32'h0)
            : rg == 2'd1 ? m_status()
            : rg == 2'd2 ? {31'h0, m_ie} : 32'h0;
        exp_q.push_back(e);
      end
      if (fl) begin
        h2c_q.delete();
        c2h_q.delete();
      end else begin
        if (hp) void'(h2c_q.pop_front());
        if (go && we && rg == 2'd0 && bus.wbs_sel_i[0]) begin
          if (h2c_q.size() < DEPTH) h2c_q.push_back(d[7:0]);
          else m_ovf = 1;
        end
        if (go && !we && rg == 2'd0) begin
          if (c2h_q.size() > 0) void'(c2h_q.pop_front());
          else m_unf = 1;
        end
        if (cp) c2h_q.push_back(c2h_data);
      end
      if (go && we && rg == 2'd1) begin
        if (d[3]) m_ovf = 0;
        if (d[4]) m_unf = 0;
      end
`ifdef WB_MAILBOX_IRQ_EN
      if (go && we && rg == 2'd2) m_ie = d[0];
      m_irq = irq0;
`endif
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack", 32'(bus.wbs_ack_o), 32'd1);
        if (e.rd) chk("rdata", bus.wbs_dat_o, e.d);
      end else begin
        chk("no_ack", 32'(bus.wbs_ack_o), 32'd0);
        chk("idle_dat", bus.wbs_dat_o, 32'd0);
      end
      chk("h2c_valid", 32'(h2c_valid), 32'(h2c_q.size() > 0));
      if (h2c_q.size() > 0) chk("h2c_data", 32'(h2c_data), 32'(h2c_q[0]));
      chk("c2h_ready", 32'(c2h_ready), 32'(c2h_q.size() < DEPTH));
      chk("irq", 32'(irq_o), 32'(m_irq));
    end
  end
  always @(negedge clk)
    if (rand_core) begin
      h2c_ready = 1'($urandom_range(0, 1));
      c2h_valid = 1'($urandom_range(0, 1));
      c2h_data = 8'($urandom);
    end
  task automatic bus_op(input bit we, input logic [1:0] rg, input logic [31:0] d = 0,
                        input logic [3:0] sel = 4'hf, input bit [1:0] core = 0);
    @(negedge clk);
    bus.wbs_cyc_i = 1;
    bus.wbs_stb_i = 1;
    bus.wbs_we_i = we;
    bus.wbs_adr_i = BASE + 32'(rg) * 4;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = sel;
    go = 1;
    if (core[0]) h2c_ready = 1;
    if (core[1]) begin
      c2h_valid = 1;
      c2h_data = 8'h77;
    end
    @(posedge clk);
    #1;
    go = 0;
    if (core[0]) h2c_ready = 0;
    if (core[1]) c2h_valid = 0;
    @(negedge clk);
    bus.wbs_cyc_i = 0;
    bus.wbs_stb_i = 0;
    bus.wbs_we_i = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.wbs_cyc_i = 0;
    bus.wbs_stb_i = 0;
    bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0;
    bus.wbs_dat_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_h2c_valid", 32'(h2c_valid), 32'd0);
    chk("rst_h2c_data", 32'(h2c_data), 32'd0);
    chk("rst_c2h_ready", 32'(c2h_ready), 32'd1);
    rst = 0;
    mon_on = 1;
    bus_op(1, 2'd0, 32'h41, 4'h1);
    bus_op(1, 2'd0, 32'h42, 4'h1);
    bus_op(0, 2'd1);
    @(negedge clk) h2c_ready = 1;
    idle(3);
    h2c_ready = 0;
    for (int i = 0; i < 5; i++) bus_op(1, 2'd0, 32'h50 + i, 4'h1);
    bus_op(1, 2'd0, 32'h99, 4'he);
    bus_op(0, 2'd1);
    bus_op(1, 2'd1, 32'h8);
    bus_op(0, 2'd1);
    bus_op(1, 2'd2, 32'h2);
    bus_op(1, 2'd2, 32'h1);
    @(negedge clk) begin
      c2h_valid = 1;
      c2h_data = 8'h5a;
    end
    @(negedge clk) c2h_valid = 0;
    chk("irq_not_yet", 32'(irq_o), 32'd0);
    @(negedge clk);
`ifdef WB_MAILBOX_IRQ_EN
    chk("irq_rise", 32'(irq_o), 32'd1);
`endif
    bus_op(0, 2'd0);
    bus_op(0, 2'd0);
    bus_op(0, 2'd1);
    bus_op(1, 2'd1, 32'h18);
    for (int i = 0; i < 4; i++) bus_op(1, 2'd0, 32'ha0 + i, 4'h1);
    bus_op(1, 2'd0, 32'hb0, 4'h1, 2'b01);
    bus_op(0, 2'd1);
    @(negedge clk) h2c_ready = 1;
    idle(5);
    h2c_ready = 0;
    @(negedge clk) begin
      bus.wbs_cyc_i = 1;
      bus.wbs_stb_i = 1;
      bus.wbs_we_i = 0;
      bus.wbs_adr_i = BASE + 32'h10;
    end
    idle(3);
    bus.wbs_cyc_i = 0;
    bus.wbs_stb_i = 0;
    @(negedge clk) begin
      bus.wbs_cyc_i = 1;
      bus.wbs_stb_i = 1;
      bus.wbs_adr_i = BASE + 32'h4;
      go = 1;
    end
    @(posedge clk);
    #1 go = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) begin
      bus.wbs_cyc_i = 0;
      bus.wbs_stb_i = 0;
    end
    bus_op(1, 2'd0, 32'h11, 4'h1);
    @(negedge clk) begin
      bus.wbs_cyc_i = 1;
      bus.wbs_stb_i = 1;
      bus.wbs_we_i = 1;
      bus.wbs_adr_i = BASE;
      bus.wbs_dat_i = 32'h22;
      bus.wbs_sel_i = 4'h1;
      go = 1;
      rst = 1;
    end
    @(posedge clk);
    #1 go = 0;
    @(negedge clk) begin
      rst = 0;
      bus.wbs_cyc_i = 0;
      bus.wbs_stb_i = 0;
      bus.wbs_we_i = 0;
    end
    bus_op(0, 2'd1);
    bus_op(1, 2'd2, 32'h1);
    bus_op(1, 2'd0, 32'h61, 4'h1);
    @(negedge clk) begin
      c2h_valid = 1;
      c2h_data = 8'h33;
    end
    @(negedge clk) c2h_valid = 0;
    bus_op(1, 2'd2, 32'h3, 4'hf, 2'b10);
    bus_op(0, 2'd1);
    bus_op(0, 2'd2);
    rand_core = 1;
    repeat (400) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 3) bus_op(1, 2'd0, d, 4'($urandom_range(0, 15)) | 4'(r != 0));
      else if (r < 5) bus_op(0, 2'd0);
      else if (r == 5) bus_op(0, 2'd1);
      else if (r == 6) bus_op(1, 2'd1, d & 32'h18);
      else if (r == 7) bus_op(1, 2'd2, {30'h0, $urandom_range(0, 7) == 0, d[0]});
      else if (r == 8) bus_op(1'(d[8]), 2'd3, d);
      else idle(1 + (d[1:0]));
      if ($urandom_range(0, 3) == 0) bus_op(0, 2'd1);
    end
    rand_core = 0;
    h2c_ready = 0;
    c2h_valid = 0;
    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
